// File: rtl/switch_allocator.sv
// switch_allocator: 5-port round-robin output allocator with wormhole locking
module switch_allocator #(
  parameter int NUM_PORTS = 5,
  parameter int PORT_W = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        in_valid,
  input  logic [NUM_PORTS*PORT_W-1:0] in_port,
  input  logic [NUM_PORTS-1:0]        in_tail,
  input  logic [NUM_PORTS-1:0]        out_ready,
  output logic [NUM_PORTS-1:0]        in_grant,
  output logic [NUM_PORTS-1:0]        out_valid,
  output logic [NUM_PORTS*PORT_W-1:0] xbar_sel,
  output logic [NUM_PORTS-1:0]        port_err
);
  typedef enum logic {IDLE, LOCKED} st_t;
  st_t               st_q  [NUM_PORTS];
  st_t               st_d  [NUM_PORTS];
  logic [PORT_W-1:0] own_q [NUM_PORTS];
  logic [PORT_W-1:0] own_d [NUM_PORTS];
  logic [PORT_W-1:0] rr_q  [NUM_PORTS];
  logic [PORT_W-1:0] rr_d  [NUM_PORTS];
  logic [NUM_PORTS-1:0] busy;
  logic              found;
  logic [PORT_W-1:0] win;
  logic [PORT_W-1:0] idx;
  logic [PORT_W:0]   sum;
  // Per-output arbitration, lock tracking and crossbar/pop generation
  always_comb begin
    st_d = st_q;
    own_d = own_q;
    rr_d = rr_q;
    in_grant = '0;
    out_valid = '0;
    xbar_sel = '0;
    port_err = '0;
    busy = '0;
    found = 1'b0;
    win = '0;
    idx = '0;
    sum = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      port_err[i] = in_valid[i] & (in_port[i*PORT_W +: PORT_W] > PORT_W'(NUM_PORTS-1));
    for (int o = 0; o < NUM_PORTS; o++)
      if (st_q[o] == LOCKED) busy[own_q[o]] = 1'b1;
    for (int o = 0; o < NUM_PORTS; o++) begin
      found = 1'b0;
      win = own_q[o];
      if (st_q[o] == LOCKED) found = in_valid[own_q[o]];
      else
        for (int k = 0; k < NUM_PORTS; k++) begin
          sum = (PORT_W+1)'(rr_q[o]) + (PORT_W+1)'(k);
          idx = (sum >= (PORT_W+1)'(NUM_PORTS)) ? PORT_W'(sum - (PORT_W+1)'(NUM_PORTS)) : PORT_W'(sum);
          if (!found && in_valid[idx] && !busy[idx] && in_port[int'(idx)*PORT_W +: PORT_W] == PORT_W'(o)) begin
            found = 1'b1;
            win = idx;
          end
        end
      if (found && out_ready[o]) begin
        out_valid[o] = 1'b1;
        xbar_sel[o*PORT_W +: PORT_W] = win;
        in_grant[win] = 1'b1;
        if (st_q[o] == IDLE) begin
          rr_d[o] = (win == PORT_W'(NUM_PORTS-1)) ? '0 : win + PORT_W'(1);
          if (!in_tail[win]) begin
            st_d[o] = LOCKED;
            own_d[o] = win;
          end
        end else if (in_tail[win]) st_d[o] = IDLE;
      end
    end
  end
  // State registers; reset drops all locks and rewinds the pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= '{default: IDLE};
      own_q <= '{default: '0};
      rr_q <= '{default: '0};
    end else begin
      st_q <= st_d;
      own_q <= own_d;
      rr_q <= rr_d;
    end
  end
endmodule
